// File: rtl/demux_destino.sv
// demux_destino: egress demultiplexer that routes upstream words to one of four destination FIFOs.
// Latency: a pop_in in cycle N gives a push in cycle N+2 when the destination is not almost full.
// Backpressure: the head word waits on its destination's almost_full and blocks all destinations.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   state             top-level FSM state; new reads only when state == STATE_ACTIVE
//   empty_in          upstream FIFO empty
//   data_in           upstream read data, valid the cycle after pop_in
//   pop_in            upstream read strobe (combinational)
//   almost_full0..3   destination FIFO k almost full
//   push0..3          destination FIFO k write strobe (combinational)
//   data_out0..3      destination FIFO k write data (zero when the head word is not for k)
//   cnt0..3           wrapping count of words pushed to destination k
//   idle              nothing held in the block and no read in flight
module demux_destino #(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter logic [3:0]  STATE_ACTIVE = 4'b0100,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            state,
  input  logic                  empty_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  pop_in,
  input  logic                  almost_full0,
  input  logic                  almost_full1,
  input  logic                  almost_full2,
  input  logic                  almost_full3,
  output logic                  push0,
  output logic                  push1,
  output logic                  push2,
  output logic                  push3,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1,
  output logic [CNT_WIDTH-1:0]  cnt2,
  output logic [CNT_WIDTH-1:0]  cnt3,
  output logic                  idle
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // rd_pending: a pop was issued last cycle, so data_in carries a word now.
  // hold: head-of-line word presented to the destinations.
  // skid: catches a word that arrives while hold is stalled.
  logic                           rd_pending_q, rd_pending_d;
  logic                           hold_valid_q, hold_valid_d;
  logic                           skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0]          hold_data_q,  hold_data_d;
  logic [DATA_WIDTH-1:0]          skid_data_q,  skid_data_d;
  logic [3:0][CNT_WIDTH-1:0]      cnt_q,        cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic       go;
  logic [1:0] occ;
  logic [1:0] occ_after;
  logic [1:0] dest;
  logic [3:0] af_vec;
  logic       drain;
  logic       hold_free;
  logic [3:0] push_vec;

  assign go     = (state == STATE_ACTIVE);
  assign af_vec = {almost_full3, almost_full2, almost_full1, almost_full0};
  assign dest   = hold_data_q[DATA_WIDTH-1 -: 2];

  // Words owned by this block: one in flight from the FIFO plus up to two stored.
  assign occ = 2'(rd_pending_q) + 2'(hold_valid_q) + 2'(skid_valid_q);

  // Reset suppresses strobes so a held word is discarded rather than pushed
  // in the very cycle reset is asserted.
  assign drain = hold_valid_q & ~af_vec[dest] & ~reset;

  // drain implies hold_valid_q, so occ >= drain and this never underflows.
  assign occ_after = occ - 2'(drain);

  // A new read is allowed only if, after this cycle's drain, a storage slot
  // is still free for the word it returns next cycle.
  assign pop_in = go & ~empty_in & ~reset & (occ_after < 2'd2);

  assign push_vec = drain ? (4'b0001 << dest) : 4'b0000;

  assign hold_free = ~hold_valid_q | drain;

  // ---------------------------------------------------------------------------
  // Capture / shift of hold and skid
  // ---------------------------------------------------------------------------
  // Order is kept by always refilling hold from skid first: skid always holds
  // a word that was read before the one currently arriving on data_in.
  always_comb begin
    rd_pending_d = pop_in;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (hold_free) begin
      if (skid_valid_q) begin
        hold_valid_d = 1'b1;
        hold_data_d  = skid_data_q;
        skid_valid_d = rd_pending_q;
        if (rd_pending_q) begin
          skid_data_d = data_in;
        end
      end else if (rd_pending_q) begin
        hold_valid_d = 1'b1;
        hold_data_d  = data_in;
      end else begin
        hold_valid_d = 1'b0;
      end
    end else if (rd_pending_q) begin
      // Hold is stalled; the occupancy limit on pop_in guarantees skid is free.
      skid_valid_d = 1'b1;
      skid_data_d  = data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Push counters (wrap naturally at 2^CNT_WIDTH)
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (push_vec[k]) begin
        cnt_d[k] = cnt_q[k] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      hold_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      hold_data_q  <= '0;
      skid_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      hold_valid_q <= hold_valid_d;
      skid_valid_q <= skid_valid_d;
      hold_data_q  <= hold_data_d;
      skid_data_q  <= skid_data_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign push0 = push_vec[0];
  assign push1 = push_vec[1];
  assign push2 = push_vec[2];
  assign push3 = push_vec[3];

  // Only the addressed destination sees the head word; others see zero.
  assign data_out0 = (dest == 2'd0) ? hold_data_q : '0;
  assign data_out1 = (dest == 2'd1) ? hold_data_q : '0;
  assign data_out2 = (dest == 2'd2) ? hold_data_q : '0;
  assign data_out3 = (dest == 2'd3) ? hold_data_q : '0;

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

  assign idle = (occ == 2'd0);

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_one_push : assert property (@(posedge clk) disable iff (reset) $onehot0(push_vec));
  a_no_ovf   : assert property (@(posedge clk) disable iff (reset)
                                !(rd_pending_q && skid_valid_q && !hold_free));
  a_occ_max  : assert property (@(posedge clk) disable iff (reset) occ != 2'd3);

endmodule

// File: tb/tb_demux_destino.sv
// tb_demux_destino: directed bench for demux_destino with a behavioural upstream FIFO.
// Latency: checks outputs cycle by cycle against hand-computed expectations.
// Backpressure: almost_full inputs are driven directly by the stimulus.
module tb_demux_destino;

  logic       clk;
  logic       reset;
  logic [3:0] state;
  logic       empty_in;
  logic [5:0] data_in;
  logic       pop_in;
  logic       almost_full0, almost_full1, almost_full2, almost_full3;
  logic       push0, push1, push2, push3;
  logic [5:0] data_out0, data_out1, data_out2, data_out3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic       idle;

  demux_destino dut (
    .clk          (clk),
    .reset        (reset),
    .state        (state),
    .empty_in     (empty_in),
    .data_in      (data_in),
    .pop_in       (pop_in),
    .almost_full0 (almost_full0),
    .almost_full1 (almost_full1),
    .almost_full2 (almost_full2),
    .almost_full3 (almost_full3),
    .push0        (push0),
    .push1        (push1),
    .push2        (push2),
    .push3        (push3),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .data_out3    (data_out3),
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .cnt2         (cnt2),
    .cnt3         (cnt3),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] fifo [$];

  // Push monitor, sampled mid-cycle.
  int push_tot [4] = '{0, 0, 0, 0};
  bit wrap_mode = 1'b0;
  int wrap_seq  = 0;
  int wrap_err  = 0;

  always @(negedge clk) begin
    if (push0) push_tot[0]++;
    if (push1) push_tot[1]++;
    if (push2) push_tot[2]++;
    if (push3) push_tot[3]++;
    if (wrap_mode && push3) begin
      if (data_out3 !== {2'b11, wrap_seq[3:0]}) wrap_err++;
      wrap_seq++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pv();
    return {push3, push2, push1, push0};
  endfunction

  function automatic logic [5:0] pdat(input int k);
    case (k)
      0:       return data_out0;
      1:       return data_out1;
      2:       return data_out2;
      default: return data_out3;
    endcase
  endfunction

  task automatic load(input logic [5:0] w);
    fifo.push_back(w);
    empty_in = 1'b0;
  endtask

  // One clock cycle; the upstream FIFO model answers a pop with data the next cycle.
  task automatic tick();
    logic p;
    #1;
    p = pop_in;
    @(posedge clk);
    #1;
    if (p && fifo.size() > 0) data_in = fifo.pop_front();
    empty_in = (fifo.size() == 0);
    #1;
  endtask

  // Stream test vectors
  logic [5:0] s_w   [4] = '{6'b00_0001, 6'b01_0010, 6'b10_0011, 6'b11_0100};
  logic       s_pop [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] s_pv  [7] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  // Backpressure release vectors
  logic       r_pop [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] r_pv  [4] = '{4'h4, 4'h4, 4'h1, 4'h0};
  int         r_k   [4] = '{2, 2, 0, 0};
  logic [5:0] r_d   [4] = '{6'b10_0001, 6'b10_0010, 6'b00_0011, 6'b00_0000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tot_before;
    bit done;

    reset = 1'b1; state = 4'b0000; empty_in = 1'b1; data_in = '0;
    almost_full0 = 1'b0; almost_full1 = 1'b0; almost_full2 = 1'b0; almost_full3 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_val("rst_pop",  pop_in, 0);
    check_val("rst_push", pv(), 0);
    check_val("rst_data", {data_out3, data_out2, data_out1, data_out0}, 0);
    check_val("rst_cnt",  {cnt3, cnt2, cnt1, cnt0}, 0);
    check_val("rst_idle", idle, 1);

    // Streaming, one word per destination.
    foreach (s_w[i]) load(s_w[i]);
    state = 4'b0100;
    #1;
    for (int i = 0; i < 7; i++) begin
      check_val("stream_pop",  pop_in, s_pop[i]);
      check_val("stream_push", pv(), s_pv[i]);
      if (i >= 2 && i <= 5) check_val("stream_dat", pdat(i - 2), s_w[i - 2]);
      tick();
    end
    check_val("stream_idle", idle, 1);
    check_val("stream_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h01010101);

    // Backpressure on destination 2: only two reads fit before the stall.
    almost_full2 = 1'b1;
    load(6'b10_0001); load(6'b10_0010); load(6'b00_0011);
    #1;
    for (int i = 0; i < 6; i++) begin
      check_val("bp_pop",  pop_in, (i < 2) ? 1 : 0);
      check_val("bp_push", pv(), 0);
      if (i >= 2) check_val("bp_busy", idle, 0);
      tick();
    end
    check_val("bp_hold_dat", data_out2, 6'b10_0001);
    almost_full2 = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val("rel_pop",  pop_in, r_pop[i]);
      check_val("rel_push", pv(), r_pv[i]);
      if (r_pv[i] != 0) check_val("rel_dat", pdat(r_k[i]), r_d[i]);
      tick();
    end
    check_val("rel_idle", idle, 1);

    // State exit with two reads in flight.
    load(6'b01_0101); load(6'b11_0110); load(6'b00_0111);
    #1;
    check_val("sx_pop0", pop_in, 1);
    tick();
    check_val("sx_pop1", pop_in, 1);
    tick();
    state = 4'b0000;
    #1;
    check_val("sx_pop_off", pop_in, 0);
    check_val("sx_push_a",  pv(), 4'h2);
    check_val("sx_dat_a",   data_out1, 6'b01_0101);
    check_val("sx_idle_a",  idle, 0);
    tick();
    check_val("sx_push_b",  pv(), 4'h8);
    check_val("sx_dat_b",   data_out3, 6'b11_0110);
    check_val("sx_idle_b",  idle, 0);
    tick();
    check_val("sx_idle_c",  idle, 1);
    check_val("sx_pop_c",   pop_in, 0);
    check_val("sx_left",    fifo.size(), 1);
    fifo.delete();
    empty_in = 1'b1;
    #1;
    check_val("pre_wrap_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h02030202);

    // Counter wrap: 256 pushes to destination 3.
    tot_before = push_tot[0] + push_tot[1] + push_tot[2];
    wrap_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      load({2'b11, iv[3:0]});
    end
    state = 4'b0100;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (idle && fifo.size() == 0) done = 1'b1;
    end
    wrap_mode = 1'b0;
    state = 4'b0000;
    check_val("wrap_done",   done, 1);
    check_val("wrap_pushes", wrap_seq, 256);
    check_val("wrap_order",  wrap_err, 0);
    check_val("wrap_others", push_tot[0] + push_tot[1] + push_tot[2], tot_before);
    check_val("wrap_cnt",    {cnt3, cnt2, cnt1, cnt0}, 32'h02030202);

    // Empty source while active.
    state = 4'b0100;
    tot_before = push_tot[0] + push_tot[1] + push_tot[2] + push_tot[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("empty_pop",  pop_in, 0);
      check_val("empty_idle", idle, 1);
      tick();
    end
    check_val("empty_push", push_tot[0] + push_tot[1] + push_tot[2] + push_tot[3], tot_before);

    // Reset mid-stream with words held and in flight.
    almost_full0 = 1'b1;
    load(6'b00_1001); load(6'b00_1010); load(6'b00_1011); load(6'b00_1100);
    tick();
    tick();
    tick();
    check_val("mr_busy", idle, 0);
    reset = 1'b1;
    state = 4'b0000;
    tick();
    reset = 1'b0;
    #1;
    check_val("mr_pop",  pop_in, 0);
    check_val("mr_push", pv(), 0);
    check_val("mr_cnt",  {cnt3, cnt2, cnt1, cnt0}, 0);
    check_val("mr_idle", idle, 1);
    tot_before = push_tot[0] + push_tot[1] + push_tot[2] + push_tot[3];
    almost_full0 = 1'b0;
    tick();
    tick();
    tick();
    check_val("mr_no_push", push_tot[0] + push_tot[1] + push_tot[2] + push_tot[3], tot_before);
    check_val("mr_idle2", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
